counter_burst_arbiter: RTL and testbench

//   Shares one 3-bit event counter (w in, count/state out) between two requesters.

---
 rtl/cba_pkg.sv | 13 +
 rtl/counter_burst_arbiter_rr_arbiter_2.sv | 20 ++
 rtl/counter_burst_arbiter.sv | 100 ++++++++++
 tb/tb_counter_burst_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cba_pkg.sv
// Shared definitions for the counter burst arbiter: FSM state encoding and
// the idle encoding of the shared event counter's state output.
package cba_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int               CNT_STATE_W = 3;
    localparam logic [CNT_STATE_W-1:0] CNT_IDLE = 3'd0;

endpackage

// File: rtl/counter_burst_arbiter_rr_arbiter_2.sv
// Two-way round-robin pick. ptr is the index of the last winner, so on a tie
// the other requester wins. Purely combinational.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] pick
);

    // One-hot winner selection
    always_comb begin
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = ptr ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/counter_burst_arbiter.sv
// Shares one 3-bit event counter between two requesters. A granted requester
// gets its latched number of w-high cycles, count pulses are totalled through
// the burst and the drain back to counter idle, and the total is returned with
// a one-cycle done pulse.
module counter_burst_arbiter
    import cba_pkg::*;
#(
    parameter int LEN_W  = 4,
    parameter int HITS_W = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0]             req,
    input  logic [LEN_W-1:0]       len0,
    input  logic [LEN_W-1:0]       len1,
    output logic [1:0]             gnt,
    output logic [1:0]             done,
    output logic [HITS_W-1:0]      hits,
    output logic                   cnt_w,
    input  logic                   cnt_count,
    input  logic [CNT_STATE_W-1:0] cnt_state
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [1:0]       pick;
    logic             ptr;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] len_pick;

    // Hit accumulator increments but never wraps past all-ones
    function automatic logic [HITS_W-1:0] sat_inc(input logic [HITS_W-1:0] v);
        return (&v) ? v : v + HITS_W'(1);
    endfunction

    rr_arbiter_2 u_rr (
        .req  (req),
        .ptr  (ptr),
        .pick (pick)
    );

    assign len_pick = pick[1] ? len1 : len0;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; a zero-length burst skips straight to the drain
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req != 2'b00) state_nxt = (len_pick != '0) ? RUN : DRAIN;
            RUN:     if (remaining == LEN_W'(1)) state_nxt = DRAIN;
            DRAIN:   if (cnt_state == CNT_IDLE) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore output decodes
    always_comb begin
        cnt_w = (state == RUN);
        done  = (state == DONE) ? gnt : 2'b00;
    end

    // Grant, length down-counter, hit accumulator and round-robin pointer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gnt       <= 2'b00;
            hits      <= '0;
            remaining <= '0;
            ptr       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        gnt       <= pick;
                        remaining <= len_pick;
                        hits      <= '0;
                    end
                end
                RUN: begin
                    remaining <= remaining - LEN_W'(1);
                    if (cnt_count) hits <= sat_inc(hits);
                end
                DRAIN: begin
                    if (cnt_count) hits <= sat_inc(hits);
                end
                DONE: begin
                    ptr <= gnt[1];
                    gnt <= 2'b00;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_burst_arbiter.sv
// Directed bench for counter_burst_arbiter. Inputs change 1 time unit after
// the rising edge and outputs are sampled at the same point.
module tb_counter_burst_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [3:0] len0, len1;
    logic [1:0] gnt, done;
    logic [3:0] hits;
    logic       cnt_w;
    logic       cnt_count;
    logic [2:0] cnt_state;

    int n_pass = 0;
    int n_tot  = 0;

    int cw, cyc;
    bit seen;
    bit any_done;

    counter_burst_arbiter #(.LEN_W(4), .HITS_W(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .len0      (len0),
        .len1      (len1),
        .gnt       (gnt),
        .done      (done),
        .hits      (hits),
        .cnt_w     (cnt_w),
        .cnt_count (cnt_count),
        .cnt_state (cnt_state)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance until done is seen or the budget runs out, counting cnt_w cycles
    task automatic wait_done(input int budget, output int w_cycles, output int ticks, output bit got);
        w_cycles = 0;
        ticks    = 0;
        got      = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            if (cnt_w) w_cycles++;
            if (done != 2'b00) got = 1'b1;
            else begin
                tick();
                ticks++;
            end
        end
    endtask

    task automatic pulse_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req       = 2'b00;
        len0      = 4'd0;
        len1      = 4'd0;
        cnt_count = 1'b0;
        cnt_state = 3'd0;
        tick();
        tick();
        chk("rst_gnt",  gnt,   2'b00);
        chk("rst_done", done,  2'b00);
        chk("rst_hits", hits,  4'd0);
        chk("rst_cntw", cnt_w, 1'b0);
        reset = 1'b0;
        tick();

        // Single request, len 3, two count pulses in RUN
        req = 2'b01; len0 = 4'd3;
        tick();
        chk("t1_gnt_run1", gnt, 2'b01);
        chk("t1_w_run1", cnt_w, 1'b1);
        req = 2'b00; len0 = 4'd9; cnt_count = 1'b1;
        tick();
        chk("t1_w_run2", cnt_w, 1'b1);
        chk("t1_hits_run2", hits, 4'd1);
        cnt_count = 1'b0;
        tick();
        chk("t1_w_run3", cnt_w, 1'b1);
        cnt_count = 1'b1;
        tick();
        chk("t1_w_drain", cnt_w, 1'b0);
        chk("t1_gnt_drain", gnt, 2'b01);
        chk("t1_done_drain", done, 2'b00);
        cnt_count = 1'b0;
        tick();
        chk("t1_done", done, 2'b01);
        chk("t1_hits", hits, 4'd2);
        chk("t1_gnt_done", gnt, 2'b01);
        tick();
        chk("t1_done_off", done, 2'b00);
        chk("t1_gnt_off", gnt, 2'b00);
        chk("t1_hits_held", hits, 4'd2);

        // Zero-length burst for requester 1; hits must clear at grant
        req = 2'b10; len1 = 4'd0;
        tick();
        chk("t3_gnt", gnt, 2'b10);
        chk("t3_hits_clr", hits, 4'd0);
        chk("t3_w_drain", cnt_w, 1'b0);
        req = 2'b00;
        tick();
        chk("t3_done", done, 2'b10);
        chk("t3_hits", hits, 4'd0);
        chk("t3_w_done", cnt_w, 1'b0);
        tick();
        chk("t3_done_off", done, 2'b00);

        // Both requesting from reset: alternate 0, 1, 0
        pulse_reset();
        req = 2'b11; len0 = 4'd2; len1 = 4'd2;
        tick();
        chk("t2_gnt_a", gnt, 2'b01);
        wait_done(10, cw, cyc, seen);
        chk("t2_seen_a", seen, 1'b1);
        chk("t2_done_a", done, 2'b01);
        chk("t2_cyc_a", cyc, 3);
        chk("t2_w_a", cw, 2);
        tick();
        chk("t2_idle_gnt", gnt, 2'b00);
        chk("t2_idle_w", cnt_w, 1'b0);
        tick();
        chk("t2_gnt_b", gnt, 2'b10);
        wait_done(10, cw, cyc, seen);
        chk("t2_seen_b", seen, 1'b1);
        chk("t2_done_b", done, 2'b10);
        tick();
        chk("t2_idle_gnt2", gnt, 2'b00);
        tick();
        chk("t2_gnt_c", gnt, 2'b01);
        req = 2'b00;
        wait_done(10, cw, cyc, seen);
        chk("t2_done_c", done, 2'b01);
        tick();

        // Saturation: len 15 with a count pulse every cycle incl. drain
        req = 2'b01; len0 = 4'd15; cnt_count = 1'b1;
        tick();
        req = 2'b00;
        wait_done(40, cw, cyc, seen);
        chk("t4_seen", seen, 1'b1);
        chk("t4_w_cycles", cw, 15);
        chk("t4_hits_sat", hits, 4'd15);
        chk("t4_done", done, 2'b01);
        cnt_count = 1'b0;
        tick();

        // Counter slow to return idle: four DRAIN cycles, lagging pulse caught
        req = 2'b01; len0 = 4'd1; cnt_state = 3'd5;
        tick();
        chk("t5_w_run", cnt_w, 1'b1);
        req = 2'b00;
        tick();
        chk("t5_w_d1", cnt_w, 1'b0);
        cnt_count = 1'b1;
        tick();
        cnt_count = 1'b0;
        chk("t5_done_d2", done, 2'b00);
        tick();
        chk("t5_done_d3", done, 2'b00);
        tick();
        chk("t5_done_d4", done, 2'b00);
        chk("t5_w_d4", cnt_w, 1'b0);
        chk("t5_gnt_d4", gnt, 2'b01);
        cnt_state = 3'd0;
        tick();
        chk("t5_done", done, 2'b01);
        chk("t5_hits", hits, 4'd1);
        tick();

        // Asynchronous reset in the middle of RUN
        req = 2'b01; len0 = 4'd5;
        tick();
        req = 2'b00;
        tick();
        chk("t6_w_before", cnt_w, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("t6_w_async", cnt_w, 1'b0);
        chk("t6_gnt_async", gnt, 2'b00);
        chk("t6_done_async", done, 2'b00);
        #2 reset = 1'b0;
        any_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done != 2'b00) any_done = 1'b1;
        end
        chk("t6_no_done", any_done, 1'b0);
        chk("t6_gnt_idle", gnt, 2'b00);
        req = 2'b11; len0 = 4'd1;
        tick();
        chk("t6_regrant", gnt, 2'b01);
        req = 2'b00;
        wait_done(10, cw, cyc, seen);
        chk("t6_seen", seen, 1'b1);
        chk("t6_done", done, 2'b01);
        chk("t6_w_cycles", cw, 1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
